// File: rtl/alu_result_capture.sv
// Samples ALU32Bit transactions into a FWFT record FIFO drained over valid/ready.
// Keeps saturating counters and, with ALU_CAP_SIGNATURE_EN defined, a 32-bit MISR over ALUResult.
module alu_result_capture #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] SIG_POLY = 32'h04C11DB7,
  parameter logic [31:0] SIG_SEED = 32'hFFFFFFFF
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         capture_en,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [3:0]                   alu_control,
  input  logic [31:0]                  alu_a,
  input  logic [31:0]                  alu_b,
  input  logic [31:0]                  alu_result,
  input  logic                         alu_zero,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [100:0]                 out_record,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             sample_count,
  output logic [CNT_W-1:0]             zero_count,
  output logic [CNT_W-1:0]             drop_count,
  output logic                         overflow,
  output logic [31:0]                  signature
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [100:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic           full, sample, pop, push, drop, wipe;
  logic [100:0]   rec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wipe       = sys_rst | clear;
  assign full       = (level_q == LW'(DEPTH));
  assign out_valid  = (level_q != '0);
  assign sample     = in_valid & capture_en;
  assign pop        = out_valid & out_ready;
  assign push       = sample & (~full | pop);
  assign drop       = sample & full & ~pop;
  assign rec        = {alu_control, alu_zero, alu_a, alu_b, alu_result};
  assign out_record = out_valid ? mem[rd_ptr_q] : '0;
  assign level      = level_q;

  always_ff @(posedge sys_clk) begin
    if (push && !wipe) mem[wr_ptr_q] <= rec;
  end

  always_ff @(posedge sys_clk) begin
    if (wipe) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_count <= '0;
      zero_count   <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      if (sample) begin
        sample_count <= sat_inc(sample_count);
        if (alu_zero) zero_count <= sat_inc(zero_count);
      end
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

`ifdef ALU_CAP_SIGNATURE_EN
  // Dropped samples still fold in, so the signature covers the whole stimulus stream.
  always_ff @(posedge sys_clk) begin
    if (wipe) begin
      signature <= SIG_SEED;
    end else if (sample) begin
      signature <= {signature[30:0], 1'b0} ^ (signature[31] ? SIG_POLY : 32'h0) ^ alu_result;
    end
  end
`else
  assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture: scoreboard queue of expected records plus counter model.
// A second instance with CNT_W=4 exercises counter saturation on the same stimulus.
module tb_alu_result_capture;

  logic         sys_clk = 1'b0;
  logic         sys_rst, capture_en, clear, in_valid, alu_zero, out_ready;
  logic [3:0]   alu_control;
  logic [31:0]  alu_a, alu_b, alu_result;

  logic         out_valid, overflow;
  logic [100:0] out_record;
  logic [4:0]   level;
  logic [15:0]  sample_count, zero_count, drop_count;
  logic [31:0]  signature;

  logic         out_valid4, overflow4;
  logic [100:0] out_record4;
  logic [4:0]   level4;
  logic [3:0]   sample_count4, zero_count4, drop_count4;
  logic [31:0]  signature4;

  always #5 sys_clk = ~sys_clk;

  alu_result_capture #(.DEPTH(16), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .capture_en(capture_en), .clear(clear),
    .in_valid(in_valid), .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_record(out_record), .level(level), .sample_count(sample_count),
    .zero_count(zero_count), .drop_count(drop_count), .overflow(overflow),
    .signature(signature)
  );

  alu_result_capture #(.DEPTH(16), .CNT_W(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .capture_en(capture_en), .clear(clear),
    .in_valid(in_valid), .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .out_valid(out_valid4), .out_ready(out_ready),
    .out_record(out_record4), .level(level4), .sample_count(sample_count4),
    .zero_count(zero_count4), .drop_count(drop_count4), .overflow(overflow4),
    .signature(signature4)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [100:0] exp_q[$];
  int           mlevel, scnt, zcnt, dcnt;
  logic         movf;
  logic [31:0]  msig;

`ifdef ALU_CAP_SIGNATURE_EN
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
`else
  localparam logic [31:0] SEED = 32'h0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mlevel = 0; scnt = 0; zcnt = 0; dcnt = 0; movf = 1'b0; msig = SEED;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_sample"}, 128'(sample_count), 128'(sat(scnt, 65535)));
    chk({tag, "_zero"}, 128'(zero_count), 128'(sat(zcnt, 65535)));
    chk({tag, "_drop"}, 128'(drop_count), 128'(sat(dcnt, 65535)));
    chk({tag, "_overflow"}, 128'(overflow), 128'(movf));
    chk({tag, "_sample4"}, 128'(sample_count4), 128'(sat(scnt, 15)));
    chk({tag, "_zero4"}, 128'(zero_count4), 128'(sat(zcnt, 15)));
  endtask

  // Check visible state, then advance one clock and update the model.
  task automatic cycle();
    logic smp, pp, fl;
    logic [100:0] rec;
    chk("level", 128'(level), 128'(mlevel));
    chk("out_valid", 128'(out_valid), 128'(mlevel != 0));
    if (mlevel != 0) chk("out_record", 128'(out_record), 128'(exp_q[0]));
    else             chk("out_record_empty", 128'(out_record), 128'(0));
    chk("signature", 128'(signature), 128'(msig));
    smp = in_valid & capture_en;
    pp  = (mlevel != 0) & out_ready;
    fl  = (mlevel == 16);
    rec = {alu_control, alu_zero, alu_a, alu_b, alu_result};
    @(posedge sys_clk);
    if (sys_rst || clear) begin
      model_reset();
    end else begin
      if (pp) begin
        void'(exp_q.pop_front());
        mlevel--;
      end
      if (smp) begin
        scnt++;
        if (alu_zero) zcnt++;
        if (fl && !pp) begin
          dcnt++;
          movf = 1'b1;
        end else begin
          exp_q.push_back(rec);
          mlevel++;
        end
`ifdef ALU_CAP_SIGNATURE_EN
        msig = {msig[30:0], 1'b0} ^ (msig[31] ? 32'h04C11DB7 : 32'h0) ^ alu_result;
`endif
      end
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z);
    in_valid = 1'b1; alu_control = c; alu_a = a; alu_b = b; alu_result = r; alu_zero = z;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; in_valid = 1'b0;
    cycle();
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; capture_en = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; alu_a = '0; alu_b = '0; alu_result = '0; alu_zero = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    chk_counts("reset_initial");

    // Reset mid-traffic with five entries held
    for (int i = 0; i < 5; i++) begin
      drive(4'(i), $urandom, $urandom, $urandom, 1'b0);
      cycle();
    end
    chk("pre_reset_level", 128'(level), 128'(5));
    sys_rst = 1'b1;
    cycle();
    cycle();
    sys_rst = 1'b0; in_valid = 1'b0;
    chk("reset_level", 128'(level), 128'(0));
    chk("reset_sig", 128'(signature), 128'(SEED));
    chk_counts("reset_mid");

    // Single pass-through
    out_ready = 1'b1;
    drive(4'h0, 32'd2, 32'd2, 32'd4, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("single_record", 128'(out_record), 128'({4'h0, 1'b0, 32'd2, 32'd2, 32'd4}));
    cycle();
    cycle();
    chk("single_level", 128'(level), 128'(0));
    chk_counts("single");

    // Fill and overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(4'($urandom), $urandom, $urandom, $urandom, (i % 3) == 0);
      cycle();
    end
    chk("fill_level", 128'(level), 128'(16));
    chk("fill_drop", 128'(drop_count), 128'(4));
    chk("fill_sample", 128'(sample_count), 128'(20));
    chk_counts("fill");

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    drive(4'hA, 32'hDEAD0001, 32'hBEEF0002, 32'h12345678, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("fullpp_level", 128'(level), 128'(16));
    chk("fullpp_drop", 128'(drop_count), 128'(4));
    for (int i = 0; i < 16; i++) cycle();
    chk("drain_level", 128'(level), 128'(0));
    chk_counts("drain");

    // Zero flag and 4-bit saturation
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(4'h6, $urandom, $urandom, 32'h0, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    chk("sat_zero4", 128'(zero_count4), 128'(15));
    chk("sat_sample4", 128'(sample_count4), 128'(15));
    chk("sat_zero16", 128'(zero_count), 128'(20));
    cycle();
    cycle();
    chk_counts("sat");

    // capture_en=0 ignores input
    capture_en = 1'b0;
    drive(4'h1, 32'h1, 32'h1, 32'h2, 1'b1);
    cycle();
    cycle();
    capture_en = 1'b1; in_valid = 1'b0;
    chk_counts("capture_off");

    // Signature single step, then clear coincident with a sample
    do_reset();
    drive(4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    cycle();
    in_valid = 1'b0;
`ifdef ALU_CAP_SIGNATURE_EN
    chk("sig_step", 128'(signature), 128'(32'hFB3EE249));
`else
    chk("sig_step", 128'(signature), 128'(32'h0));
`endif
    out_ready = 1'b0;
    drive(4'h2, 32'h5, 32'h6, 32'h11, 1'b0);
    clear = 1'b1;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_sig", 128'(signature), 128'(SEED));
    chk("clear_level", 128'(level), 128'(0));
    cycle();
    chk_counts("clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
